// File: rtl/axi_rd_pkg.sv
// Shared constants for the AXI read-channel arbiter: FSM state encoding,
// AXI burst/response codes, requester IDs and grant-vector bit positions.
package axi_rd_pkg;

   // FSM state encoding (legacy-compatible plain constants)
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] AR   = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   // AXI protocol codes
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // ARID per requester
   localparam logic [3:0] ID_IC = 4'd0;
   localparam logic [3:0] ID_DC = 4'd1;

   // Bit positions inside the two-bit request/grant vectors
   localparam int GNT_IC = 0;
   localparam int GNT_DC = 1;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-input arbiter, one-hot grant. Default: fixed priority, D-cache first.
// With ARB_RR_EN defined: on a tie, grant the requester not granted last.
module rr_arb2
   import axi_rd_pkg::*;
(
   input  logic [1:0] req,
`ifdef ARB_RR_EN
   input  logic       last_dc,
`endif
   output logic [1:0] gnt
);

   // Resolve a tie; a single requester always wins outright
   always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
      gnt = req;
      if (req == 2'b11) begin
`ifdef ARB_RR_EN
         gnt = last_dc ? (2'b01 << GNT_IC) : (2'b01 << GNT_DC);
`else
         gnt = 2'b01 << GNT_DC;
`endif
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between the I-cache and D-cache refill FSMs.
// One INCR burst outstanding at a time; returned beats are routed only to the
// granted requester. Optional macro ARB_RR_EN selects round-robin arbitration
// (default: fixed priority, D-cache first).
module axi_rd_arbiter
   import axi_rd_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned IC_BEATS = 16,
   parameter int unsigned DC_BEATS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_rd_req,
   input  logic [ADDR_W-1:0] ic_rd_addr,
   output logic              ic_rd_rdy,
   output logic              ic_ret_valid,
   output logic              ic_ret_last,
   input  logic              ic_ret_ready,
   input  logic              dc_rd_req,
   input  logic [ADDR_W-1:0] dc_rd_addr,
   output logic              dc_rd_rdy,
   output logic              dc_ret_valid,
   output logic              dc_ret_last,
   input  logic              dc_ret_ready,
   output logic [DATA_W-1:0] ret_data,
   output logic              ret_err,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic [3:0]        arid,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic              proto_err
);

   localparam logic [2:0] ARSIZE   = 3'($clog2(DATA_W / 8));
   localparam logic [7:0] IC_ARLEN = 8'(IC_BEATS - 1);
   localparam logic [7:0] DC_ARLEN = 8'(DC_BEATS - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [7:0]        arlen_q, arlen_d;
   logic [3:0]        arid_q, arid_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              proto_err_q, proto_err_d;
   logic [1:0]        gnt;

`ifdef ARB_RR_EN
   logic              last_dc_q, last_dc_d;
`endif

   logic in_ar, in_data, is_dc, ar_hs, r_hs;

   rr_arb2 u_arb (
      .req     ({dc_rd_req, ic_rd_req}),
`ifdef ARB_RR_EN
      .last_dc (last_dc_q),
`endif
      .gnt     (gnt)
   );

   assign in_ar   = (state_q == AR);
   assign in_data = (state_q == DATA);
   assign is_dc   = (arid_q == ID_DC);
   assign ar_hs   = in_ar && arready;
   assign r_hs    = in_data && rvalid && rready;

   // AR channel driven straight from the latched request registers
   assign araddr  = araddr_q;
   assign arlen   = arlen_q;
   assign arsize  = ARSIZE;
   assign arburst = AXI_BURST_INCR;
   assign arid    = arid_q;
   assign arvalid = in_ar;

   // Request acknowledge and beat routing toward the granted requester only
   assign ic_rd_rdy    = ar_hs && !is_dc;
   assign dc_rd_rdy    = ar_hs && is_dc;
   assign rready       = in_data && (is_dc ? dc_ret_ready : ic_ret_ready);
   assign ic_ret_valid = in_data && !is_dc && rvalid;
   assign dc_ret_valid = in_data && is_dc && rvalid;
   assign ic_ret_last  = in_data && !is_dc && rlast;
   assign dc_ret_last  = in_data && is_dc && rlast;
   assign ret_data     = rdata;
   assign ret_err      = in_data && (rresp != AXI_RESP_OKAY);
   assign proto_err    = proto_err_q;

   // Next-state logic: arbitrate and latch in IDLE, wait for AR, count beats
   always_comb begin
      state_d     = state_q;
      araddr_d    = araddr_q;
      arlen_d     = arlen_q;
      arid_d      = arid_q;
      cnt_d       = cnt_q;
      proto_err_d = proto_err_q;
`ifdef ARB_RR_EN
      last_dc_d   = last_dc_q;
`endif
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               araddr_d = gnt[GNT_DC] ? dc_rd_addr : ic_rd_addr;
               arlen_d  = gnt[GNT_DC] ? DC_ARLEN : IC_ARLEN;
               arid_d   = gnt[GNT_DC] ? ID_DC : ID_IC;
               cnt_d    = 8'd0;
               state_d  = AR;
            end
         end
         AR: begin
            if (arready) begin
               state_d = DATA;
`ifdef ARB_RR_EN
               last_dc_d = is_dc;
`endif
            end
         end
         DATA: begin
            if (r_hs) begin
               cnt_d = cnt_q + 8'd1;
               // Early rlast, or final counted beat without rlast
               if (rlast != (cnt_q == arlen_q)) proto_err_d = 1'b1;
               if (rlast) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and register update with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q     <= IDLE;
         araddr_q    <= '0;
         arlen_q     <= '0;
         arid_q      <= '0;
         cnt_q       <= '0;
         proto_err_q <= 1'b0;
`ifdef ARB_RR_EN
         last_dc_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         araddr_q    <= araddr_d;
         arlen_q     <= arlen_d;
         arid_q      <= arid_d;
         cnt_q       <= cnt_d;
         proto_err_q <= proto_err_d;
`ifdef ARB_RR_EN
         last_dc_q   <= last_dc_d;
`endif
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter. Inputs are driven on the falling
// edge and outputs sampled 1 time unit later. Expected values come from a
// small behavioural model (arbitration rule, sticky protocol flag, spacing).
// Honours ARB_RR_EN the same way as the design.
module tb_axi_rd_arbiter;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int IC_BEATS = 16;
   localparam int DC_BEATS = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              ic_rd_req, dc_rd_req;
   logic [ADDR_W-1:0] ic_rd_addr, dc_rd_addr;
   logic              ic_rd_rdy, dc_rd_rdy;
   logic              ic_ret_valid, ic_ret_last, ic_ret_ready;
   logic              dc_ret_valid, dc_ret_last, dc_ret_ready;
   logic [DATA_W-1:0] ret_data;
   logic              ret_err;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [3:0]        arid;
   logic              arvalid, arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast, rvalid, rready, proto_err;

   axi_rd_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IC_BEATS(IC_BEATS), .DC_BEATS(DC_BEATS)
   ) dut (
      .clk(clk), .rst(rst),
      .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
      .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_ready(ic_ret_ready),
      .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
      .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_ready(dc_ret_ready),
      .ret_data(ret_data), .ret_err(ret_err),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit m_proto   = 1'b0;
   bit m_last_dc = 1'b0;
   int t_last    = -100;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Winner by rule: 1 = D-cache, 0 = I-cache
   function automatic bit pick(input bit ic, input bit dc);
      if (ic && dc) begin
`ifdef ARB_RR_EN
         return !m_last_dc;
`else
         return 1'b1;
`endif
      end
      return dc;
   endfunction

   // One complete burst. last_at: beat number carrying rlast; err_at: beat
   // number with SLVERR (0 = none); stall_at: beat index where the granted
   // requester holds ready low for 3 cycles (-1 = none); ar_dly: arready
   // delay (-1 = random); b2b: expect minimum spacing after previous burst;
   // rst_after: assert reset once this many beats are done (-1 = never).
   task automatic burst(input int last_at, input int err_at, input int stall_at,
                        input bit dense, input int ar_dly, input bit b2b,
                        input int rst_after);
      bit                win, done, rdy_g, found;
      int                beat, stall, d;
      logic [ADDR_W-1:0] exp_addr;
      logic [7:0]        exp_len;

      win      = pick(ic_rd_req, dc_rd_req);
      exp_addr = win ? dc_rd_addr : ic_rd_addr;
      exp_len  = win ? 8'(DC_BEATS - 1) : 8'(IC_BEATS - 1);

      // Wait for AR; stray rvalid in IDLE must be ignored
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         arready = 1'b0;
         rvalid  = 1'($urandom_range(0, 1));
         rlast   = 1'($urandom_range(0, 1));
         ic_ret_ready = 1'b1;
         dc_ret_ready = 1'b1;
         #1;
         if (arvalid) begin
            found = 1'b1;
            break;
         end
         check("idle_rready", rready, 0);
         check("idle_valid", {ic_ret_valid, dc_ret_valid}, 0);
      end
      check("arvalid_seen", found, 1);
      if (!found) return;
      if (b2b) check("b2b_gap", cyc - t_last, 2);
      check("araddr", araddr, exp_addr);
      check("arlen", arlen, exp_len);
      check("arid", arid, win ? 4'd1 : 4'd0);
      check("arsize", arsize, 3'd2);
      check("arburst", arburst, 2'b01);

      // AR phase with live address inputs scrambled to prove latching
      d = (ar_dly < 0) ? $urandom_range(0, 3) : ar_dly;
      for (int i = 0; i <= d; i++) begin
         if (i > 0) begin
            @(negedge clk);
            ic_rd_addr = $urandom;
            dc_rd_addr = $urandom;
            rvalid     = 1'($urandom_range(0, 1));
         end
         arready = (i == d);
         #1;
         check("ar_hold", {arvalid, araddr}, {1'b1, exp_addr});
         check("ar_rready", rready, 0);
         check("ic_rd_rdy", ic_rd_rdy, (i == d) && !win);
         check("dc_rd_rdy", dc_rd_rdy, (i == d) && win);
      end
      m_last_dc = win;

      // Data phase
      beat  = 0;
      stall = 0;
      done  = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         if (win) dc_rd_req = 1'b0; else ic_rd_req = 1'b0;
         arready = 1'b0;
         if (rst_after >= 0 && beat == rst_after) begin
            rst = 1'b1;
            rvalid = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            ic_rd_req = 1'b0;
            dc_rd_req = 1'b0;
            m_proto   = 1'b0;
            m_last_dc = 1'b0;
            #1;
            check("rst_arvalid", arvalid, 0);
            check("rst_rready", rready, 0);
            check("rst_valid", {ic_ret_valid, dc_ret_valid}, 0);
            check("rst_proto", proto_err, m_proto);
            return;
         end
         rvalid = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
         rdata  = $urandom;
         rlast  = (beat == last_at - 1);
         rresp  = (beat == err_at - 1) ? 2'b10 : 2'b00;
         if (stall_at >= 0 && beat == stall_at && stall < 3) begin
            rdy_g  = 1'b0;
            rvalid = 1'b1;
            stall++;
         end else begin
            rdy_g = dense ? 1'b1 : ($urandom_range(0, 4) != 0);
         end
         if (win) begin
            dc_ret_ready = rdy_g;
            ic_ret_ready = 1'($urandom_range(0, 1));
         end else begin
            ic_ret_ready = rdy_g;
            dc_ret_ready = 1'($urandom_range(0, 1));
         end
         #1;
         check("rready", rready, rdy_g);
         check("win_valid", win ? dc_ret_valid : ic_ret_valid, rvalid);
         check("other_valid", win ? ic_ret_valid : dc_ret_valid, 0);
         check("win_last", win ? dc_ret_last : ic_ret_last, rlast);
         check("other_last", win ? ic_ret_last : dc_ret_last, 0);
         check("data_rdy", {ic_rd_rdy, dc_rd_rdy}, 0);
         check("proto_err", proto_err, m_proto);
         if (rvalid) begin
            check("ret_data", ret_data, rdata);
            check("ret_err", ret_err, beat == err_at - 1);
         end
         if (rvalid && rdy_g) begin
            if (rlast != (beat == int'(exp_len))) m_proto = 1'b1;
            beat++;
            if (rlast) begin
               done   = 1'b1;
               t_last = cyc;
            end
         end
      end
      check("burst_done", done, 1);
      check("beat_count", beat, last_at);
   endtask

   task automatic set_req(input bit ic, input bit dc);
      @(negedge clk);
      ic_rd_req  = ic;
      dc_rd_req  = dc;
      ic_rd_addr = $urandom & 32'hFFFF_FFC0;
      dc_rd_addr = $urandom & 32'hFFFF_FFC0;
   endtask

   initial begin
      rst = 1'b1;
      ic_rd_req = 0; dc_rd_req = 0; ic_rd_addr = 0; dc_rd_addr = 0;
      ic_ret_ready = 0; dc_ret_ready = 0; arready = 0;
      rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
      repeat (3) @(negedge clk);
      rvalid = 1'b1;
      #1;
      check("reset_arvalid", arvalid, 0);
      check("reset_ar_fields", {araddr, arlen, arid}, 0);
      check("reset_rready", rready, 0);
      check("reset_outs", {ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid}, 0);
      check("reset_proto", proto_err, 0);
      @(negedge clk);
      rst = 1'b0;
      rvalid = 1'b0;

      // I-cache alone, fixed address, arready after 2 cycles, dense beats
      @(negedge clk);
      ic_rd_req  = 1'b1;
      ic_rd_addr = 32'h1C00_0040;
      burst(16, 0, -1, 1'b1, 2, 1'b0, -1);

      // Simultaneous requests, two rounds, then a tie after a D-cache grant
      set_req(1, 1);
      burst(16, 0, -1, 1'b0, -1, 1'b0, -1);
      burst(16, 0, -1, 1'b0, -1, 1'b1, -1);
      set_req(1, 1);
      burst(16, 0, -1, 1'b0, -1, 1'b0, -1);
      burst(16, 0, -1, 1'b0, -1, 1'b1, -1);
      set_req(0, 1);
      burst(16, 0, -1, 1'b0, -1, 1'b0, -1);
      set_req(1, 1);
      burst(16, 0, -1, 1'b0, -1, 1'b0, -1);
      burst(16, 0, -1, 1'b0, -1, 1'b1, -1);

      // D-cache ready held low for 3 cycles mid-burst
      set_req(0, 1);
      burst(16, 0, 5, 1'b1, 1, 1'b0, -1);

      // Early rlast on beat 8, then a clean burst with the flag still set
      set_req(1, 0);
      burst(8, 0, -1, 1'b1, 0, 1'b0, -1);
      set_req(0, 1);
      burst(16, 0, -1, 1'b0, -1, 1'b0, -1);

      // Error response on beat 5
      set_req(1, 0);
      burst(16, 5, -1, 1'b0, -1, 1'b0, -1);

      // rlast missing on the counted final beat, arriving on beat 18
      set_req(0, 1);
      burst(18, 0, -1, 1'b0, -1, 1'b0, -1);

      // Randomised traffic
      for (int k = 0; k < 12; k++) begin
         int r;
         r = $urandom_range(1, 3);
         set_req(r[0], r[1]);
         burst(16, $urandom_range(0, 16), ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : -1,
               1'b0, -1, 1'b0, -1);
         if (ic_rd_req || dc_rd_req)
            burst(16, 0, -1, 1'b0, -1, 1'b1, -1);
      end

      // Reset in the middle of a burst, after 6 beats, then a clean burst
      set_req(0, 1);
      burst(16, 0, -1, 1'b1, 1, 1'b0, 6);
      set_req(1, 0);
      burst(16, 0, -1, 1'b0, -1, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
